// File: rtl/serpent_block_loader.sv
// Packs 32-bit words into 128-bit Serpent blocks and queues them in a small
// first-word-fall-through FIFO for the initial permutation stage.
module serpent_block_loader #(
  parameter int FIFO_DEPTH = 2,
  parameter bit MSW_FIRST  = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_word_valid,
  input  logic [31:0]  i_word,
  input  logic         i_word_last,
  output logic         o_word_ready,
  output logic         o_blk_valid,
  output logic [127:0] o_blk_data,
  input  logic         i_blk_ready,
  output logic         o_frame_err,
  output logic [1:0]   o_fifo_level
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0]   wcnt_q, wcnt_d;
  logic [95:0]  stage_q, stage_d;
  logic [127:0] ent0_q, ent0_d;
  logic [127:0] ent1_q, ent1_d;
  logic [1:0]   level_q, level_d;
  logic         err_q, err_d;

  logic         word_xfer;
  logic         blk_push;
  logic         blk_pop;
  logic         frame_viol;
  logic [127:0] new_blk;

  // Readiness looks only at registered level, so a pop never enables a push
  // in the same cycle and a full FIFO is never written.
  assign o_word_ready = !i_clear && ((wcnt_q != 2'd3) || (level_q < DEPTH));
  assign word_xfer    = i_word_valid && o_word_ready;
  assign blk_push     = word_xfer && (wcnt_q == 2'd3);
  assign frame_viol   = word_xfer && i_word_last && (wcnt_q != 2'd3);
  assign blk_pop      = (level_q != 2'd0) && i_blk_ready && !i_clear;

  assign new_blk = MSW_FIRST ? {stage_q[31:0], stage_q[63:32], stage_q[95:64], i_word}
                             : {i_word, stage_q[95:64], stage_q[63:32], stage_q[31:0]};

  always_comb begin
    wcnt_d  = wcnt_q;
    stage_d = stage_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    level_d = level_q;
    err_d   = frame_viol;

    if (i_clear) begin
      wcnt_d  = 2'd0;
      level_d = 2'd0;
    end else begin
      if (frame_viol) begin
        wcnt_d = 2'd0;
      end else if (word_xfer) begin
        wcnt_d = wcnt_q + 2'd1;
        case (wcnt_q)
          2'd0:    stage_d[31:0]  = i_word;
          2'd1:    stage_d[63:32] = i_word;
          2'd2:    stage_d[95:64] = i_word;
          default: ;
        endcase
      end

      // ent0 is always the head; on an emptying pop it keeps its old value.
      case ({blk_push, blk_pop})
        2'b10: begin
          if (level_q == 2'd0) ent0_d = new_blk;
          else                 ent1_d = new_blk;
          level_d = level_q + 2'd1;
        end
        2'b01: begin
          if (level_q == 2'd2) ent0_d = ent1_q;
          level_d = level_q - 2'd1;
        end
        2'b11: begin
          if (level_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = new_blk;
          end else begin
            ent0_d = new_blk;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wcnt_q  <= 2'd0;
      stage_q <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      level_q <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      stage_q <= stage_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  assign o_blk_valid  = (level_q != 2'd0);
  assign o_blk_data   = ent0_q;
  assign o_fifo_level = level_q;
  assign o_frame_err  = err_q;

endmodule

// File: doc/serpent_block_loader.md
# serpent_block_loader

Gathers 32-bit input words into 128-bit Serpent plaintext/ciphertext blocks and hands them, via a small output FIFO with a valid/ready handshake, to the Serpent initial permutation stage directly downstream. It decouples the word-wide data path (XTS tweak/data mover) from the block-wide cipher core. It also checks message framing (end-of-message marker only on a block boundary) and supports a synchronous flush.

## Interface
- FIFO_DEPTH, 2: output block FIFO depth; legal values 1 or 2.
- MSW_FIRST, 0: 0 means the first word of a block lands in [31:0] (Serpent little-endian order); 1 means the first word lands in [127:96].
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_clear  in  1  synchronous flush of the partial block and the FIFO; has priority over all other inputs.
- i_word_valid  in  1  input word valid.
- i_word  in  32  input word.
- i_word_last  in  1  final word of a message; qualified by i_word_valid.
- o_word_ready  out  1  loader accepts a word this cycle.
- o_blk_valid  out  1  o_blk_data holds a complete block.
- o_blk_data  out  128  assembled block, feeds the IP stage.
- i_blk_ready  in  1  downstream accepts the block.
- o_frame_err  out  1  one-cycle pulse on a framing violation.
- o_fifo_level  out  2  number of blocks held in the FIFO, 0..FIFO_DEPTH.

## Operation
- A word transfer occurs when i_word_valid && o_word_ready. A block transfer occurs when o_blk_valid && i_blk_ready.
- Assembly state:
  - 2-bit word counter wcnt, 0..3, wraps 3→0.
  - 96-bit staging register for words 0..2.
- Placement with MSW_FIRST=0: word k goes to bits [32k+31:32k]. With MSW_FIRST=1, word k goes to bits [127-32k:96-32k].
- o_word_ready = !i_clear && (wcnt != 3 || fifo_level < FIFO_DEPTH).
  - No combinational path exists from i_blk_ready to o_word_ready.
  - A push into a full FIFO is therefore impossible.
- On a transfer with wcnt==3:
  - The staging register plus i_word are pushed as one block.
  - wcnt returns to 0.
- Framing rule: if i_word_last is set on a transfer with wcnt != 3:
  - The word is consumed and discarded.
  - The partial block is discarded and wcnt is set to 0.
  - o_frame_err pulses high in the next cycle.
  - Nothing is pushed.
- i_word_last on the 4th word is legal and pushes normally.
- FIFO behaviour:
  - First-word-fall-through: o_blk_data shows the head entry.
  - o_blk_valid = (level != 0).
  - Push and pop in the same cycle leave the level unchanged, and entry order is preserved.
  - While o_blk_valid && !i_blk_ready, o_blk_data is stable.
  - When the FIFO is empty, o_blk_data holds its last value (don't-care to the consumer).
- i_clear:
  - In the same cycle, o_word_ready is low.
  - At the edge, wcnt → 0, level → 0, and the staging register is not cleared.
  - A block transfer in a clear cycle is ignored: downstream must not rely on it.
  - No o_frame_err is raised.
- Reset values: wcnt 0, level 0, o_blk_valid 0, o_blk_data 0, o_frame_err 0, o_fifo_level 0. o_word_ready is 1 once i_rst_n is high and i_clear is low.
- Reset asserted mid-block or mid-handshake drops everything immediately and asynchronously.

## Timing
- Latency: when the 4th word is accepted at edge N, o_blk_valid is high in the cycle after edge N. That is 1 cycle from the last word to the block.
- Sustained throughput: 1 word per cycle, i.e. 1 block per 4 cycles, when i_blk_ready is held high (any FIFO_DEPTH).
- FIFO_DEPTH=1 with downstream stalled: the 4th word of the next block is held off until the pop edge. o_word_ready rises in the cycle after the pop.
- o_frame_err is registered: exactly one cycle high per violation; back-to-back violations give back-to-back pulses.
- o_fifo_level is registered and updates at the edge of push, pop or clear.

## Test plan
- Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles, MSW_FIRST=0, i_blk_ready=1 → one cycle after the 4th word, o_blk_data = 0x0F0E0D0C_0B0A0908_07060504_03020100 and o_blk_valid is high for exactly 1 cycle.
- Same words with MSW_FIRST=1 → o_blk_data = 0x03020100_07060504_0B0A0908_0F0E0D0C.
- Three blocks streamed with i_blk_ready=0, FIFO_DEPTH=2:
  - o_fifo_level reaches 2.
  - o_word_ready drops only at wcnt==3 of block 3.
  - Raising i_blk_ready pops blocks 1, 2, 3 in order with data stable while stalled.
- i_word_last on the 2nd word → o_frame_err high for 1 cycle, nothing pushed. The next 4 words form a correct block.
- i_clear after 2 words with 1 block queued:
  - o_fifo_level → 0 and o_blk_valid → 0 next cycle.
  - The following 4 words yield exactly one correct block.
- i_rst_n pulsed low mid-block (wcnt=2, level=1) → all outputs return to reset values asynchronously. Afterwards a fresh 4-word block is output correctly.
